// File: rtl/input_buffer_controller.sv
// Router input-port receive buffer: zero-idle link capture into a DEPTH-entry FIFO with
// show-ahead valid/ready output. Optional macro INBUF_ALMOST_FULL_EN raises full early by AF_MARGIN.
module input_buffer_controller #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_MARGIN  = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic [AW:0]           count
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_param_err
        $error("input_buffer_controller: DEPTH must be a power of two >= 2 and AF_MARGIN in 1..DEPTH-1");
    end

`ifdef INBUF_ALMOST_FULL_EN
    localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - AF_MARGIN);
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;
    logic          wr_gate, wr_acc, rd_acc;

    always_comb begin
`ifdef INBUF_ALMOST_FULL_EN
        // Slots above the threshold still absorb words already in flight upstream.
        wr_gate = 1'b1;
`else
        wr_gate = !full_q;
`endif
        wr_acc   = (Data_in != '0) && (count_q < DEPTH_CNT) && wr_gate;
        rd_acc   = valid_q && ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
`ifdef INBUF_ALMOST_FULL_EN
        full_d  = (count_d >= AF_THRESH);
`else
        full_d  = (count_d == DEPTH_CNT);
`endif
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    // Storage is deliberately not reset; count/valid guard every read of it.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q] <= Data_in;
    end

    assign Data_out = valid_q ? mem[rd_ptr_q] : '0;
    assign full     = full_q;
    assign valid    = valid_q;
    assign count    = count_q;

endmodule

// File: tb/tb_input_buffer_controller.sv
// Self-checking bench for input_buffer_controller: queue-based reference model plus directed
// and random traffic. Honours INBUF_ALMOST_FULL_EN when it is defined for the build.
module tb_input_buffer_controller;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AF = 1;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          full;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          ready = 1'b0;
    logic [AW:0]   count;

    int checks = 0;
    int failures = 0;
    bit model_ok = 1'b0;
    logic [DW-1:0] sb_q[$];

    input_buffer_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AF)) dut (
        .clk(clk), .rst(rst), .Data_in(data_in), .full(full),
        .Data_out(data_out), .valid(valid), .ready(ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_full();
`ifdef INBUF_ALMOST_FULL_EN
        return sb_q.size() >= DEPTH - AF;
`else
        return sb_q.size() == DEPTH;
`endif
    endfunction

    // Called at a negedge: check state left by the last edge, drive inputs, predict the next edge.
    task automatic step(input logic [DW-1:0] din, input bit rdy, input bit r);
        bit rd, wr, gate;
        logic [DW-1:0] exp_w;
        rst = r;
        data_in = din;
        ready = rdy;
        if (model_ok) begin
            chk("count", 32'(count), 32'(sb_q.size()));
            chk("full", 32'(full), 32'(model_full()));
            chk("valid", 32'(valid), 32'(sb_q.size() != 0));
            chk("data_out", 32'(data_out), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
        end
        if (r) begin
            sb_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
`ifdef INBUF_ALMOST_FULL_EN
            gate = 1'b1;
`else
            gate = !model_full();
`endif
            rd = (sb_q.size() != 0) && rdy;
            wr = (din != '0) && (sb_q.size() < DEPTH) && gate;
            if (rd) begin
                exp_w = sb_q.pop_front();
                chk("sb_pop", 32'(data_out), 32'(exp_w));
            end
            if (wr) sb_q.push_back(din);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // T1 reset with data held on the link
        step(8'h3C, 1'b0, 1'b1);
        step(8'h3C, 1'b0, 1'b1);
        chk("t1_count", 32'(count), 0);
        chk("t1_full", 32'(full), 0);
        chk("t1_valid", 32'(valid), 0);
        chk("t1_dout", 32'(data_out), 0);
        step(8'h3C, 1'b0, 1'b0);
        chk("t1_valid_after", 32'(valid), 1);
        chk("t1_dout_after", 32'(data_out), 32'h3C);
        step(8'h00, 1'b1, 1'b0);
        chk("t1_drained", 32'(count), 0);

        // T2 fill with 55 held afterwards
        step(8'h11, 1'b0, 1'b0);
        step(8'h22, 1'b0, 1'b0);
        step(8'h33, 1'b0, 1'b0);
        step(8'h44, 1'b0, 1'b0);
        chk("t2_count", 32'(count), 4);
        chk("t2_full", 32'(full), 1);
        step(8'h55, 1'b0, 1'b0);
        step(8'h55, 1'b0, 1'b0);
        chk("t2_no_write", 32'(count), 4);

        // T3 drain order; 55 enters one cycle after the first pop
        step(8'h55, 1'b1, 1'b0);
        chk("t3_count_pop1", 32'(count), 3);
`ifndef INBUF_ALMOST_FULL_EN
        chk("t3_full_drop", 32'(full), 0);
`endif
        step(8'h55, 1'b1, 1'b0);
        chk("t3_count_55", 32'(count), 3);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0);
        chk("t3_valid_end", 32'(valid), 0);
        chk("t3_dout_end", 32'(data_out), 0);

        // T4 idle filter, with stray ready while empty
        for (int i = 0; i < 5; i++) step(8'h00, i[0], 1'b0);
        chk("t4_count", 32'(count), 0);

        // T5 simultaneous read/write across pointer wrap
        step(8'h01, 1'b0, 1'b0);
        step(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(8'hA0 + 8'(i), 1'b1, 1'b0);
        chk("t5_count", 32'(count), 2);
        chk("t5_head", 32'(data_out), 32'hAA);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("t5_empty", 32'(count), 0);

        // Reset mid-traffic discards contents and ignores the reset-cycle write
        step(8'h61, 1'b0, 1'b0);
        step(8'h62, 1'b0, 1'b0);
        step(8'h77, 1'b1, 1'b1);
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_valid", 32'(valid), 0);
        step(8'h00, 1'b0, 1'b0);

`ifdef INBUF_ALMOST_FULL_EN
        // T6 early full and in-flight absorption
        step(8'hC1, 1'b0, 1'b0);
        step(8'hC2, 1'b0, 1'b0);
        step(8'hC3, 1'b0, 1'b0);
        chk("t6_full_at3", 32'(full), 1);
        step(8'hC4, 1'b0, 1'b0);
        chk("t6_count4", 32'(count), 4);
        step(8'hC5, 1'b0, 1'b0);
        chk("t6_drop5", 32'(count), 4);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom_range(1, 255));
            step(d, $urandom_range(0, 3) != 0, 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(8'h00, 1'b1, 1'b0);
        chk("final_empty", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
